// File: rtl/step_dir_position_monitor_if.sv
// APB3 bus bundle for the step/dir position monitor.
interface step_dir_position_monitor_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/step_dir_position_monitor.sv
// Two-axis step/dir receiver: synchronizes step/dir lines, counts step rising edges into signed
// 32-bit positions, flags soft travel limits. Optional step/dir glitch filter: STEP_GLITCH_FILTER_EN.
module step_dir_position_monitor #(
  parameter int SYNC_STAGES = 2
`ifdef STEP_GLITCH_FILTER_EN
  , parameter int FILTER_CYCLES = 4
`endif
) (
  input  logic                               PCLK,
  input  logic                               PRESERN,
  step_dir_position_monitor_if.slave         apb,
  input  logic                               step1_in,
  input  logic                               dir1_in,
  input  logic                               step2_in,
  input  logic                               dir2_in,
  output logic                               limit_irq
);

  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  // Line order matches STAT[7:4]: step1, dir1, step2, dir2.
  logic [3:0] raw_in;
  logic [3:0] synced;
  logic [3:0] line_s;

  assign raw_in = {dir2_in, step2_in, dir1_in, step1_in};

  logic        wr_en;
  logic [2:0]  idx;
  logic [31:0] limit_q, limit_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic        irq_q, irq_d;
  logic [1:0][31:0] pos_val;
  logic [1:0]  lim_flag;
  logic [31:0] rdata;
  logic        unused_addr;

  assign wr_en       = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign idx         = apb.PADDR[4:2];
  assign unused_addr = ^{apb.PADDR[31:5], apb.PADDR[1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_line
      logic [NS-1:0] sync_q, sync_d;

      always_comb sync_d = {sync_q[NS-2:0], raw_in[gi]};

      always_ff @(posedge PCLK) begin
        if (PRESERN) sync_q <= '0;
        else         sync_q <= sync_d;
      end

      assign synced[gi] = sync_q[NS-1];

`ifdef STEP_GLITCH_FILTER_EN
      localparam int FN = (FILTER_CYCLES < 1) ? 1 : FILTER_CYCLES;
      localparam int CW = $clog2(FN + 1);
      logic          filt_q, filt_d;
      logic [CW-1:0] fcnt_q, fcnt_d;

      // The counter tracks how long the synced line has disagreed with the accepted level.
      always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (synced[gi] != filt_q) begin
          if (fcnt_q == CW'(FN - 1)) filt_d = synced[gi];
          else                       fcnt_d = fcnt_q + 1'b1;
        end
      end

      always_ff @(posedge PCLK) begin
        if (PRESERN) begin
          filt_q <= 1'b0;
          fcnt_q <= '0;
        end else begin
          filt_q <= filt_d;
          fcnt_q <= fcnt_d;
        end
      end

      assign line_s[gi] = filt_q;
`else
      assign line_s[gi] = synced[gi];
`endif
    end

    for (gi = 0; gi < 2; gi++) begin : g_axis
      logic        step_s, dir_s, rise;
      logic        step_prev_q, step_prev_d;
      logic [31:0] pos_q, pos_d;
      logic [31:0] mag;
      logic        lim_q, lim_d;

      assign step_s = line_s[2*gi];
      assign dir_s  = line_s[2*gi+1];

      always_comb begin
        step_prev_d = step_s;
        rise        = step_s & ~step_prev_q;
        // A register write in the same cycle as a step edge takes priority and drops the step.
        pos_d = pos_q;
        if (wr_en && idx == 3'(gi))
          pos_d = apb.PWDATA;
        else if (rise && ctrl_q[gi])
          pos_d = dir_s ? pos_q + 32'd1 : pos_q - 32'd1;

        mag   = pos_q[31] ? (~pos_q + 32'd1) : pos_q;
        lim_d = lim_q;
        if (wr_en && idx == 3'd4 && apb.PWDATA[gi]) lim_d = 1'b0;
        if (limit_q != 32'd0 && mag >= limit_q)     lim_d = 1'b1;
      end

      always_ff @(posedge PCLK) begin
        if (PRESERN) begin
          step_prev_q <= 1'b0;
          pos_q       <= '0;
          lim_q       <= 1'b0;
        end else begin
          step_prev_q <= step_prev_d;
          pos_q       <= pos_d;
          lim_q       <= lim_d;
        end
      end

      assign pos_val[gi]  = pos_q;
      assign lim_flag[gi] = lim_q;
    end
  endgenerate

  always_comb begin
    limit_d = limit_q;
    ctrl_d  = ctrl_q;
    if (wr_en && idx == 3'd2) limit_d = apb.PWDATA;
    if (wr_en && idx == 3'd3) ctrl_d  = apb.PWDATA[3:0];
    irq_d = |(lim_flag & ctrl_q[3:2]);
  end

  always_ff @(posedge PCLK) begin
    if (PRESERN) begin
      limit_q <= '0;
      ctrl_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      limit_q <= limit_d;
      ctrl_q  <= ctrl_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (apb.PSEL && !apb.PWRITE) begin
      case (idx)
        3'd0:    rdata = pos_val[0];
        3'd1:    rdata = pos_val[1];
        3'd2:    rdata = limit_q;
        3'd3:    rdata = {28'd0, ctrl_q};
        3'd4:    rdata = {24'd0, line_s, 2'b00, lim_flag};
        default: rdata = '0;
      endcase
    end
  end

  assign apb.PRDATA  = rdata;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = 1'b0;
  assign limit_irq   = irq_q;

endmodule

// File: tb/tb_step_dir_position_monitor.sv
// Randomized self-checking bench for step_dir_position_monitor against a pulse-counting model.
module tb_step_dir_position_monitor;

  localparam int SYNC = 2;
`ifdef STEP_GLITCH_FILTER_EN
  localparam int LAT = SYNC + 1 + 4;
`else
  localparam int LAT = SYNC + 1;
`endif

  logic PCLK = 1'b0;
  logic PRESERN = 1'b1;
  logic step1_in = 1'b0, dir1_in = 1'b0, step2_in = 1'b0, dir2_in = 1'b0;
  logic limit_irq;

  step_dir_position_monitor_if bus();

  step_dir_position_monitor dut (
    .PCLK      (PCLK),
    .PRESERN   (PRESERN),
    .apb       (bus.slave),
    .step1_in  (step1_in),
    .dir1_in   (dir1_in),
    .step2_in  (step2_in),
    .dir2_in   (dir2_in),
    .limit_irq (limit_irq)
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: what firmware should observe, derived from the pulses the bench sends.
  logic [31:0] m_pos [2];
  logic [31:0] m_limit;
  logic [3:0]  m_ctrl;
  logic        m_lim [2];
  logic        m_dir [2];
  logic [31:0] rd_pos [2];
  logic [31:0] rd_stat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  function automatic longint unsigned magnitude(input logic [31:0] v);
    longint s;
    s = longint'($signed(v));
    if (s < 0) s = -s;
    return longint'(s);
  endfunction

  task automatic m_eval();
    for (int a = 0; a < 2; a++)
      if (m_limit != 0 && magnitude(m_pos[a]) >= longint'(m_limit)) m_lim[a] = 1'b1;
  endtask

  task automatic m_reset();
    m_pos[0] = '0; m_pos[1] = '0; m_limit = '0; m_ctrl = '0;
    m_lim[0] = 1'b0; m_lim[1] = 1'b0;
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge PCLK);
    bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PENABLE = 1'b0; bus.PADDR = addr; bus.PWDATA = data;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    @(negedge PCLK);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge PCLK);
    bus.PSEL = 1'b1; bus.PWRITE = 1'b0; bus.PENABLE = 1'b0; bus.PADDR = addr;
    #1 data = bus.PRDATA;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    @(negedge PCLK);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  function automatic logic [31:0] mk_addr(input int reg_idx);
    logic [31:0] junk;
    junk = $urandom;
    return (junk & 32'hFFFF_FFE0) | (32'(reg_idx) << 2);
  endfunction

  task automatic do_write(input int reg_idx, input logic [31:0] data);
    apb_write(mk_addr(reg_idx), data);
    case (reg_idx)
      0: m_pos[0] = data;
      1: m_pos[1] = data;
      2: m_limit  = data;
      3: m_ctrl   = data[3:0];
      4: begin
        if (data[0]) m_lim[0] = 1'b0;
        if (data[1]) m_lim[1] = 1'b0;
      end
      default: ;
    endcase
    m_eval();
  endtask

  task automatic pulse(input logic [1:0] mask, input logic [1:0] dirs);
    @(negedge PCLK);
    if (mask[0]) begin dir1_in = dirs[0]; m_dir[0] = dirs[0]; end
    if (mask[1]) begin dir2_in = dirs[1]; m_dir[1] = dirs[1]; end
    repeat (8) @(negedge PCLK);
    step1_in = mask[0]; step2_in = mask[1];
    repeat (6) @(negedge PCLK);
    step1_in = 1'b0; step2_in = 1'b0;
    repeat (8) @(negedge PCLK);
    for (int a = 0; a < 2; a++)
      if (mask[a] && m_ctrl[a]) m_pos[a] = m_dir[a] ? m_pos[a] + 32'd1 : m_pos[a] - 32'd1;
    m_eval();
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_stat;
    logic        exp_irq;
    repeat (8) @(negedge PCLK);
    apb_read(mk_addr(0), rd_pos[0]);
    apb_read(mk_addr(1), rd_pos[1]);
    apb_read(mk_addr(4), rd_stat);
    exp_stat = {24'd0, m_dir[1], 1'b0, m_dir[0], 1'b0, 2'b00, m_lim[1], m_lim[0]};
    exp_irq  = (m_lim[0] & m_ctrl[2]) | (m_lim[1] & m_ctrl[3]);
    check({tag, ".pos1"}, rd_pos[0], m_pos[0]);
    check({tag, ".pos2"}, rd_pos[1], m_pos[1]);
    check({tag, ".stat"}, rd_stat, exp_stat);
    check({tag, ".irq"}, {31'd0, limit_irq}, {31'd0, exp_irq});
  endtask

  task automatic check_cfg(input string tag);
    logic [31:0] v;
    apb_read(mk_addr(2), v);
    check({tag, ".limit"}, v, m_limit);
    apb_read(mk_addr(3), v);
    check({tag, ".ctrl"}, v, {28'd0, m_ctrl});
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int op, a;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
    m_reset(); m_dir[0] = 1'b0; m_dir[1] = 1'b0;
    repeat (4) @(negedge PCLK);
    PRESERN = 1'b0;
    check_all("reset");
    check_cfg("reset");

    // T1: ten forward pulses on axis 1
    do_write(3, 32'h3);
    for (int i = 0; i < 10; i++) pulse(2'b01, 2'b01);
    check_all("t1");
    check("t1.pos1_abs", rd_pos[0], 32'd10);

    // T2: three reverse pulses on axis 2 from zero
    do_write(1, 32'h0);
    for (int i = 0; i < 3; i++) pulse(2'b10, 2'b00);
    check_all("t2");
    check("t2.pos2_abs", rd_pos[1], 32'hFFFF_FFFD);

    // T3: wrap past the positive maximum
    do_write(0, 32'h7FFF_FFFF);
    pulse(2'b01, 2'b01);
    check_all("t3");
    check("t3.pos1_abs", rd_pos[0], 32'h8000_0000);

    // T4: limit flag, irq, W1C while condition still holds
    do_write(2, 32'd5);
    do_write(3, 32'hF);
    check_all("t4");
    check("t4.lim1", {31'd0, rd_stat[0]}, 32'd1);
    check("t4.irq_abs", {31'd0, limit_irq}, 32'd1);
    do_write(4, 32'h1);
    check_all("t4w1c");
    check("t4w1c.lim1", {31'd0, rd_stat[0]}, 32'd1);

    // T5: position write lands on the same edge as a counted step
    @(negedge PCLK);
    step1_in = 1'b1;
    repeat (LAT - 3) @(negedge PCLK);
    apb_write(mk_addr(0), 32'h100);
    m_pos[0] = 32'h100;
    m_eval();
    repeat (6) @(negedge PCLK);
    step1_in = 1'b0;
    check_all("t5");
    check("t5.pos1_abs", rd_pos[0], 32'h100);
    do_write(3, 32'h0);
    for (int i = 0; i < 5; i++) pulse(2'b01, 2'b01);
    check_all("t5dis");

    // T6: two-cycle glitch on step1
    do_write(3, 32'h1);
    @(negedge PCLK);
    step1_in = 1'b1;
    repeat (2) @(negedge PCLK);
    step1_in = 1'b0;
    repeat (12) @(negedge PCLK);
`ifndef STEP_GLITCH_FILTER_EN
    m_pos[0] = m_pos[0] + 32'd1;
`endif
    m_eval();
    check_all("t6");

    // Reset asserted in the middle of a step pulse
    do_write(3, 32'hF);
    @(negedge PCLK);
    step1_in = 1'b1;
    @(negedge PCLK);
    PRESERN = 1'b1;
    step1_in = 1'b0;
    repeat (3) @(negedge PCLK);
    PRESERN = 1'b0;
    m_reset();
    check_all("rst_mid");
    check_cfg("rst_mid");

    // Randomized register traffic and pulse trains
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 9);
      case (op)
        0: begin
          a = $urandom_range(0, 1);
          if ($urandom_range(0, 3) == 0) v = $urandom;
          else v = 32'(int'($urandom_range(0, 40)) - 20);
          do_write(a, v);
        end
        1: do_write(3, $urandom);
        2: begin
          if ($urandom_range(0, 3) == 0) v = 32'd0;
          else v = 32'($urandom_range(1, 25));
          do_write(2, v);
        end
        3: do_write(4, ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3)));
        4: begin
          a = $urandom_range(5, 7);
          do_write(a, $urandom);
          apb_read(mk_addr(a), v);
          check($sformatf("rnd%0d.reserved", it), v, 32'd0);
        end
        5: check_cfg($sformatf("rnd%0d", it));
        default: pulse(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)));
      endcase
      check_all($sformatf("rnd%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
